// File: rtl/ser_link_pkg.sv
// ser_link_pkg: shared TX state encoding and parameter defaults for the serial link
package ser_link_pkg;
    localparam int DATA_W_DEF     = 8;
    localparam int MSB_FIRST_DEF  = 1;
    localparam int PARITY_EN_DEF  = 1;
    localparam int PARITY_ODD_DEF = 0;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} tx_state_e;
endpackage

// File: rtl/ser_link_if.sv
// ser_link_if: parallel load/send and received-word bundle of the serial link
interface ser_link_if import ser_link_pkg::*; #(parameter int DATA_W = DATA_W_DEF) ();
    logic [DATA_W-1:0] din;
    logic              load;
    logic              send;
    logic              busy;
    logic              ser_data;
    logic              ser_vld;
    logic              ser_last;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic              par_err;
    modport master (
        output din, load, send,
        input  busy, ser_data, ser_vld, ser_last, dout, dout_vld, par_err
    );
    modport slave (
        input  din, load, send,
        output busy, ser_data, ser_vld, ser_last, dout, dout_vld, par_err
    );
endinterface

// File: rtl/ser_rx.sv
// ser_rx: deserialises a frame, checks parity and presents the word with a one-cycle valid
module ser_rx import ser_link_pkg::*; #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MSB_FIRST  = MSB_FIRST_DEF,
    parameter int PARITY_EN  = PARITY_EN_DEF,
    parameter int PARITY_ODD = PARITY_ODD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_data,
    input  logic              ser_vld,
    input  logic              ser_last,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              par_err
);
    localparam int CW = $clog2(DATA_W + 2);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d, sh_in, dout_q, dout_d;
    logic              vld_q, vld_d, err_q, err_d, is_data, frame_end;
    always_comb begin
        is_data   = cnt_q < CW'(DATA_W);
        frame_end = ser_vld && ser_last;
        sh_in     = MSB_FIRST != 0 ? {sh_q[DATA_W-2:0], ser_data} : {ser_data, sh_q[DATA_W-1:1]};
        sh_d      = ser_vld && is_data ? sh_in : sh_q;
        // a gap in ser_vld discards the partial frame by restarting the count
        cnt_d     = ser_vld && !ser_last ? cnt_q + 1'b1 : '0;
        dout_d    = frame_end ? (PARITY_EN != 0 ? sh_q : sh_in) : dout_q;
        vld_d     = frame_end;
        err_d     = frame_end && PARITY_EN != 0 && (ser_data != (^sh_q ^ (PARITY_ODD != 0)));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sh_q   <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end
    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign par_err  = err_q;
endmodule

// File: rtl/ser_link.sv
// ser_link: double-buffered serialiser with optional parity feeding an on-chip receiver
module ser_link import ser_link_pkg::*; #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MSB_FIRST  = MSB_FIRST_DEF,
    parameter int PARITY_EN  = PARITY_EN_DEF,
    parameter int PARITY_ODD = PARITY_ODD_DEF
) (
    input logic       clk,
    input logic       rst,
    ser_link_if.slave bus
);
    localparam int CW = $clog2(DATA_W);
    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              hold_vld_q, hold_vld_d, par_q, par_d, start, last_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
        end
    end
    // a load coinciding with send feeds the new word straight into the frame
    always_comb begin
        hold_d     = bus.load ? bus.din : hold_q;
        start      = bus.send && (bus.load || hold_vld_q) && state_q == IDLE;
        last_data  = state_q == SHIFT && cnt_q == CW'(DATA_W - 1);
        hold_vld_d = !start && (bus.load || hold_vld_q);
        shift_d    = start ? hold_d :
                     state_q != SHIFT ? shift_q :
                     MSB_FIRST != 0 ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};
        cnt_d      = state_q == SHIFT && !last_data ? cnt_q + 1'b1 : '0;
        par_d      = start ? ^hold_d ^ (PARITY_ODD != 0) : par_q;
        state_d    = state_q == IDLE  ? (start ? SHIFT : IDLE) :
                     state_q == SHIFT ? (last_data ? (PARITY_EN != 0 ? PARITY : IDLE) : SHIFT) :
                     IDLE;
    end
    always_comb begin
        bus.busy     = state_q != IDLE;
        bus.ser_vld  = state_q != IDLE;
        bus.ser_data = state_q == SHIFT ? (MSB_FIRST != 0 ? shift_q[DATA_W-1] : shift_q[0]) :
                       state_q == PARITY && par_q;
        bus.ser_last = state_q == PARITY || (last_data && PARITY_EN == 0);
    end
    ser_rx #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST),
        .PARITY_EN (PARITY_EN),
        .PARITY_ODD(PARITY_ODD)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .ser_data(bus.ser_data),
        .ser_vld (bus.ser_vld),
        .ser_last(bus.ser_last),
        .dout    (bus.dout),
        .dout_vld(bus.dout_vld),
        .par_err (bus.par_err)
    );
endmodule
